// File: rtl/pc_sequencer.sv
// Next-PC sequencer with halt/stall control and an optional return-address stack.
// Define PC_SEQ_RAS_EN to build the RAS; without it call/return degrade to plain jumps.
//
//   state  | meaning
//   RUN    | pc advances each cycle unless stalled
//   HALTED | pc and RAS frozen until reset
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter int              RAS_DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            halt,
    input  logic [2:0]      op,
    input  logic            cond,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] jreg,
    output logic [XLEN-1:0] pc,
    output logic            halted,
    output logic            ras_ovf,
    output logic            ras_unf
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic            advance;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] jmp_tgt;
    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] ret_tgt;

    assign seq_pc  = pc + XLEN'(4);
    assign jmp_tgt = {pc[XLEN-1:18], imm[15:0], 2'b00};
    // Shift within XLEN so the two top imm bits fall off, as intended.
    assign br_tgt  = pc + (imm << 2);
    assign halted  = (state == HALTED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            pc    <= RESET_VECTOR;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        advance   = 1'b0;
        case (state)
            RUN: begin
                if (halt)
                    state_nxt = HALTED;
                else if (!stall)
                    advance = 1'b1;
            end
            HALTED: state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        pc_nxt = pc;
        if (advance) begin
            case (op)
                3'b000, 3'b001: pc_nxt = seq_pc;
                3'b010:         pc_nxt = jmp_tgt;
                3'b011:         pc_nxt = ret_tgt;
                3'b100:         pc_nxt = jmp_tgt;
                3'b101:         pc_nxt = jreg;
                3'b110, 3'b111: pc_nxt = cond ? br_tgt : seq_pc;
                default:        pc_nxt = seq_pc;
            endcase
        end
    end

`ifdef PC_SEQ_RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   ras_ptr;
    logic [CW-1:0]   ras_cnt;
    logic            ras_full;
    logic            ras_empty;
    logic            do_call;
    logic            do_ret;

    // ras_ptr is the next free slot; once full it also addresses the oldest entry.
    assign ras_full  = (ras_cnt == CW'(RAS_DEPTH));
    assign ras_empty = (ras_cnt == '0);
    assign do_call   = advance && (op == 3'b010);
    assign do_ret    = advance && (op == 3'b011);
    assign ret_tgt   = ras_empty ? jreg : ras_mem[ras_ptr - PW'(1)];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
        end else begin
            ras_ovf <= do_call && ras_full;
            ras_unf <= do_ret && ras_empty;
            if (do_call) begin
                ras_ptr <= ras_ptr + PW'(1);
                if (!ras_full)
                    ras_cnt <= ras_cnt + CW'(1);
            end else if (do_ret && !ras_empty) begin
                ras_ptr <= ras_ptr - PW'(1);
                ras_cnt <= ras_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_call && !reset)
            ras_mem[ras_ptr] <= seq_pc;
    end
`else
    assign ret_tgt = jreg;
    assign ras_ovf = 1'b0;
    assign ras_unf = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer against a queue-based next-PC model.
module tb_pc_sequencer;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        halt  = 1'b0;
    logic        cond  = 1'b0;
    logic [2:0]  op    = 3'd0;
    logic [31:0] imm   = '0;
    logic [31:0] jreg  = '0;
    logic [31:0] pc;
    logic        halted;
    logic        ras_ovf;
    logic        ras_unf;

    pc_sequencer #(.XLEN(XLEN), .RAS_DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
        .clk(clk), .reset(reset), .stall(stall), .halt(halt), .op(op),
        .cond(cond), .imm(imm), .jreg(jreg), .pc(pc), .halted(halted),
        .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    logic [31:0] m_pc;
    bit          m_halted, m_ovf, m_unf;
    logic [31:0] m_ras[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".halted"}, 32'(halted), 32'(m_halted));
        check({tag, ".ovf"}, 32'(ras_ovf), 32'(m_ovf));
        check({tag, ".unf"}, 32'(ras_unf), 32'(m_unf));
    endtask

    function automatic void model_reset();
        m_pc = RV;
        m_halted = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_ras.delete();
    endfunction

    function automatic void model_step(input logic [2:0] o, input logic c, input logic [31:0] i,
                                       input logic [31:0] j, input logic s, input logic h);
        logic [31:0] tgt;
        tgt = (m_pc & 32'hFFFC_0000) | ((i & 32'h0000_FFFF) * 32'd4);
        m_ovf = 1'b0;
        m_unf = 1'b0;
        if (m_halted) return;
        if (h) begin
            m_halted = 1'b1;
            return;
        end
        if (s) return;
        case (o)
            3'd0, 3'd1: m_pc = m_pc + 32'd4;
            3'd4:       m_pc = tgt;
            3'd5:       m_pc = j;
            3'd6, 3'd7: m_pc = c ? m_pc + i * 32'd4 : m_pc + 32'd4;
            3'd2: begin
`ifdef PC_SEQ_RAS_EN
                m_ras.push_back(m_pc + 32'd4);
                if (m_ras.size() > DEPTH) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1'b1;
                end
`endif
                m_pc = tgt;
            end
            default: begin
`ifdef PC_SEQ_RAS_EN
                if (m_ras.size() > 0)
                    m_pc = m_ras.pop_back();
                else begin
                    m_pc = j;
                    m_unf = 1'b1;
                end
`else
                m_pc = j;
`endif
            end
        endcase
    endfunction

    // Called just after a rising edge; drives inputs, waits one edge, checks.
    task automatic step(input logic [2:0] o, input logic c, input logic [31:0] i,
                        input logic [31:0] j, input logic s, input logic h, input string tag);
        op = o; cond = c; imm = i; jreg = j; stall = s; halt = h;
        @(posedge clk);
        #1;
        model_step(o, c, i, j, s, h);
        check_all(tag);
    endtask

    // Asserts reset mid-cycle with garbage inputs, checks the async effect, releases off-edge.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b1;
        op = 3'($urandom); halt = 1'($urandom); stall = 1'($urandom);
        imm = $urandom; jreg = $urandom; cond = 1'($urandom);
        #1;
        model_reset();
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] saved;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("rst");
        #1;
        reset = 1'b0;

        repeat (3) step(3'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "seq");
        check("seq_c", pc, 32'hC);

        step(3'd4, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, "j100");
        step(3'd6, 1'b1, 32'h3, 32'h0, 1'b0, 1'b0, "br_t");
        check("br_taken", pc, 32'h10C);
        step(3'd4, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, "j100b");
        step(3'd6, 1'b0, 32'h3, 32'h0, 1'b0, 1'b0, "br_nt");
        check("br_not_taken", pc, 32'h104);
        step(3'd4, 1'b0, 32'h43, 32'h0, 1'b0, 1'b0, "j10c");
        step(3'd6, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, "br_neg");
        check("br_back", pc, 32'h108);

        repeat (3) step(3'd4, 1'b0, 32'h80, 32'h0, 1'b1, 1'b0, "stall");
        check("stall_hold", pc, 32'h108);
        step(3'd4, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, "unstall");
        check("unstall_jump", pc, 32'h200);

`ifdef PC_SEQ_RAS_EN
        do_reset("ras_rst");
        for (int k = 1; k <= 5; k++)
            step(3'd2, 1'b0, 32'(k * 16), 32'h0, 1'b0, 1'b0, "call");
        check("ovf_pulse", 32'(ras_ovf), 32'd1);
        step(3'd3, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "ret1");
        check("ret1_pc", pc, 32'h104);
        check("ovf_gone", 32'(ras_ovf), 32'd0);
        step(3'd3, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "ret2");
        check("ret2_pc", pc, 32'hC4);
        step(3'd3, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "ret3");
        check("ret3_pc", pc, 32'h84);
        step(3'd3, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "ret4");
        check("ret4_pc", pc, 32'h44);
        step(3'd3, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "ret_stalled");
        step(3'd3, 1'b0, 32'h0, 32'h200, 1'b0, 1'b0, "ret5");
        check("ret5_pc", pc, 32'h200);
        check("unf_pulse", 32'(ras_unf), 32'd1);
        step(3'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "after_unf");
`else
        do_reset("noras_rst");
        step(3'd6, 1'b1, 32'h048D_159E, 32'h0, 1'b0, 1'b0, "far");
        step(3'd2, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, "call_as_jmp");
        check("call_as_jmp_pc", pc, 32'h1234_0080);
        step(3'd3, 1'b0, 32'h0, 32'h300, 1'b0, 1'b0, "ret_as_jreg");
        check("ret_as_jreg_pc", pc, 32'h300);
`endif

        step(3'($urandom), 1'b0, $urandom, $urandom, 1'b1, 1'b1, "halt");
        check("halted_set", 32'(halted), 32'd1);
        saved = m_pc;
        for (int k = 0; k < 10; k++)
            step(3'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom), "frozen");
        check("frozen_pc", pc, saved);
        do_reset("halt_rst");
        check("reset_pc", pc, RV);

        for (int k = 0; k < 400; k++) begin
            if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0)
                do_reset("rnd_rst");
            else
                step(3'($urandom_range(0, 7)), 1'($urandom),
                     $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 255)),
                     $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
